// File: rtl/tone_sequencer_if.sv
// Note-table read bus between tone_sequencer (master) and the external ROM/LUT (slave).
// The table is read combinationally at rom_addr.
interface tone_sequencer_if #(
  parameter int width = 16,
  parameter int AW    = 5,
  parameter int DUR_W = 8
);
  logic [AW-1:0]    rom_addr;
  logic [width-1:0] rom_divisor;
  logic [DUR_W-1:0] rom_duration;

  modport master (output rom_addr, input rom_divisor, input rom_duration);
  modport slave  (input rom_addr, output rom_divisor, output rom_duration);
endinterface

// File: rtl/tone_sequencer.sv
// Steps through an external note table and feeds each divisor to the clock divider for D ticks.
// Optional TONE_SEQ_GAP_EN adds a one-tick muted GAP after every note.
module tone_sequencer #(
  parameter int width       = 16,
  parameter int AW          = 5,
  parameter int DUR_W       = 8,
  parameter int TICK_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  tone_sequencer_if.master    rom,
  output logic [width-1:0]    divisor,
  output logic                tone_en,
  output logic                busy,
  output logic                done
);
  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

`ifdef TONE_SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             tick;
  logic             note_end;
  logic             last_addr;

  assign tick      = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign last_addr = (rom.rom_addr == '1);

  // note_end marks the cycle after which the current entry is finished (incl. any gap)
  always_comb begin
    note_end = 1'b0;
`ifdef TONE_SEQ_GAP_EN
    note_end = (state == GAP) && tick;
`else
    note_end = (state == PLAY) && tick && (dur_cnt == DUR_W'(1));
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rom.rom_addr <= '0;
      divisor      <= '0;
      tone_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tick_cnt     <= '0;
      dur_cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) begin
        state        <= IDLE;
        rom.rom_addr <= '0;
        divisor      <= '0;
        tone_en      <= 1'b0;
        busy         <= 1'b0;
        tick_cnt     <= '0;
        dur_cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            rom.rom_addr <= '0;
            divisor      <= '0;
            tone_en      <= 1'b0;
            busy         <= 1'b0;
            if (start && !stop) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            if (rom.rom_duration == '0) begin
              // an empty song (marker at entry 0) never loops
              if (rom.rom_addr == '0 || !loop) begin
                state   <= IDLE;
                done    <= 1'b1;
                busy    <= 1'b0;
                divisor <= '0;
                tone_en <= 1'b0;
              end else begin
                rom.rom_addr <= '0;
              end
            end else begin
              divisor  <= rom.rom_divisor;
              tone_en  <= (rom.rom_divisor != '0);
              dur_cnt  <= rom.rom_duration;
              tick_cnt <= '0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
`ifdef TONE_SEQ_GAP_EN
              if (dur_cnt == DUR_W'(1)) begin
                state   <= GAP;
                tone_en <= 1'b0;
              end
`endif
            end
          end
`ifdef TONE_SEQ_GAP_EN
          GAP: tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
`endif
          default: state <= IDLE;
        endcase

        // end of table behaves like a marker at a nonzero address
        if (note_end) begin
          if (!last_addr) begin
            rom.rom_addr <= rom.rom_addr + AW'(1);
            state        <= LOAD;
          end else if (loop) begin
            rom.rom_addr <= '0;
            state        <= LOAD;
          end else begin
            state        <= IDLE;
            done         <= 1'b1;
            busy         <= 1'b0;
            rom.rom_addr <= '0;
            divisor      <= '0;
            tone_en      <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer (TICK_CYCLES=4, AW=2); ROM modelled as a small table.
module tb_tone_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [15:0] divisor;
  logic        tone_en, busy, done;
  int          vectors = 0;
  int          errs = 0;

  logic [15:0] tbl_div [4];
  logic [7:0]  tbl_dur [4];

  tone_sequencer_if #(.width(16), .AW(2), .DUR_W(8)) rif ();
  assign rif.rom_divisor  = tbl_div[rif.rom_addr];
  assign rif.rom_duration = tbl_dur[rif.rom_addr];

  tone_sequencer #(.width(16), .AW(2), .DUR_W(8), .TICK_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .rom(rif.master), .divisor(divisor), .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tbl(input logic [15:0] d0, input logic [7:0] u0,
                         input logic [15:0] d1, input logic [7:0] u1,
                         input logic [15:0] d2, input logic [7:0] u2,
                         input logic [15:0] d3, input logic [7:0] u3);
    tbl_div[0] = d0; tbl_dur[0] = u0;
    tbl_div[1] = d1; tbl_dur[1] = u1;
    tbl_div[2] = d2; tbl_dur[2] = u2;
    tbl_div[3] = d3; tbl_dur[3] = u3;
  endtask

  // pulse start in the current cycle (cycle 0); returns in cycle 1
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    set_tbl(16'd10, 8'd2, 16'd6, 8'd1, 16'd0, 8'd0, 16'd0, 8'd0);
    step(2);
    check("rst_divisor", {16'h0, divisor}, 32'd0);
    check("rst_flags", {tone_en, busy, done}, 3'b000);
    check("rst_addr", rif.rom_addr, 2'd0);
    reset_n = 1'b1;
    step();

    // basic song, loop=0
    kick();
    check("t1_c1_busy", {busy, done}, 2'b10);
    check("t1_c1_div", divisor, 16'd0);
    step();
    check("t1_c2_div", divisor, 16'd10);
    check("t1_c2_ten", tone_en, 1'b1);
    step(7);
    check("t1_c9_div", divisor, 16'd10);
    step();
    check("t1_c10_load_div", divisor, 16'd10);
    check("t1_c10_addr", rif.rom_addr, 2'd1);
    step();
    check("t1_c11_div", divisor, 16'd6);
    step(3);
    check("t1_c14_div", divisor, 16'd6);
    step();
    check("t1_c15_addr", rif.rom_addr, 2'd2);
    check("t1_c15_done", done, 1'b0);
    step();
    check("t1_c16_flags", {tone_en, busy, done}, 3'b001);
    check("t1_c16_div", divisor, 16'd0);
    step();
    check("t1_c17_done", done, 1'b0);

    // same table, loop=1
    loop = 1'b1;
    kick();
    step(14);
    check("t2_c15_addr", rif.rom_addr, 2'd2);
    step();
    check("t2_c16_addr", rif.rom_addr, 2'd0);
    check("t2_c16_hold", {divisor, busy, done}, {16'd6, 2'b10});
    step();
    check("t2_c17_div", divisor, 16'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_stop", {divisor, tone_en, busy, done}, {16'd0, 3'b000});
    loop = 1'b0;

    // rest entry
    set_tbl(16'd0, 8'd3, 16'd7, 8'd1, 16'd0, 8'd0, 16'd0, 8'd0);
    kick();
    step();
    check("t3_c2_rest", {divisor, tone_en, busy}, {16'd0, 2'b01});
    step(11);
    check("t3_c13_rest", {divisor, tone_en, busy}, {16'd0, 2'b01});
    step(2);
    check("t3_c15_note", {divisor, tone_en}, {16'd7, 1'b1});
    step(5);
    check("t3_end_done", done, 1'b1);

    // stop mid-note, then start+stop together from IDLE
    set_tbl(16'd10, 8'd2, 16'd6, 8'd1, 16'd0, 8'd0, 16'd0, 8'd0);
    kick();
    step(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_c6_stop", {divisor, tone_en, busy, done}, {16'd0, 3'b000});
    check("t4_c6_addr", rif.rom_addr, 2'd0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("t4_ss_idle", busy, 1'b0);
    step();
    check("t4_ss_idle2", busy, 1'b0);

    // asynchronous reset between edges
    kick();
    step(3);
    check("t5_pre_div", divisor, 16'd10);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_div", divisor, 16'd0);
    check("t5_async_flags", {tone_en, busy, done}, 3'b000);
    check("t5_async_addr", rif.rom_addr, 2'd0);
    step();
    reset_n = 1'b1;
    step();
    kick();
    step();
    check("t5_restart_div", divisor, 16'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // full table, no marker: end at last address
    set_tbl(16'd1, 8'd1, 16'd2, 8'd1, 16'd3, 8'd1, 16'd4, 8'd1);
    kick();
    step(19);
    check("t6_c20_last", {divisor, 14'd0, rif.rom_addr}, {16'd4, 16'd3});
    step();
    check("t6_c21_done", {busy, done}, 2'b01);
    check("t6_c21_addr", rif.rom_addr, 2'd0);
    step();

    // full table with loop: wraps to entry 0
    loop = 1'b1;
    kick();
    step(20);
    check("t6l_c21_load", {divisor, busy, done}, {16'd4, 2'b10});
    check("t6l_c21_addr", rif.rom_addr, 2'd0);
    step();
    check("t6l_c22_div", divisor, 16'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // empty song with loop=1 finishes
    set_tbl(16'd9, 8'd0, 16'd2, 8'd1, 16'd3, 8'd1, 16'd4, 8'd1);
    kick();
    check("t7_c1_busy", busy, 1'b1);
    step();
    check("t7_c2_done", {busy, done}, 2'b01);
    check("t7_c2_div", divisor, 16'd0);
    step();
    check("t7_c3_idle", {busy, done}, 2'b00);
    loop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Upstream feeder for the variable clock divider.
- Steps through an external note table (divisor + duration per entry) and presents each note's divisor for a timed interval. The divider turns each divisor into an audible/visible tone clock.
- Provides start/stop/loop control, a rest (mute) indication, and an end-of-song pulse.
- Table storage (ROM or case-statement LUT) is external and read combinationally.

Parameters:
- width, 16, divisor width; must match the downstream divider's width.
- AW, 5, table address width; table depth is 2^AW.
- DUR_W, 8, note duration width, counted in ticks.
- TICK_CYCLES, 50000, clock cycles per duration tick (1 ms at 50 MHz); must be >= 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin playback from entry 0; ignored while busy.
- stop  input  1  abort playback; level or pulse.
- loop  input  1  sampled at end of table: 1 restarts at entry 0, 0 finishes.
- rom_addr  output  AW  current table address.
- rom_divisor  input  width  divisor at rom_addr; 0 means rest.
- rom_duration  input  DUR_W  duration at rom_addr, in ticks; 0 means end-of-song marker.
- divisor  output  width  divisor to the divider (registered).
- tone_en  output  1  1 while a non-rest note plays; downstream gates the divided clock with it.
- busy  output  1  1 in any state other than IDLE.
- done  output  1  one-cycle pulse when playback finishes normally.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - rom_addr=0, divisor=0, tone_en=0, busy=0, done=0.
  - Tick and duration counters cleared.
- States: IDLE, LOAD, PLAY (plus GAP with the optional feature). All outputs are registered.
- IDLE:
  - rom_addr=0, divisor=0, tone_en=0, busy=0.
  - start=1 and stop=0: go to LOAD, busy=1.
- LOAD (exactly 1 cycle; samples rom_* at rom_addr):
  - If rom_duration==0 and (rom_addr==0 or loop==0): go to IDLE, done=1 for the next cycle, divisor=0, tone_en=0. An empty song (marker at entry 0) never loops.
  - If rom_duration==0, rom_addr!=0 and loop==1: rom_addr<=0, stay in LOAD.
  - Otherwise:
    - divisor<=rom_divisor, tone_en<=(rom_divisor!=0), dur_cnt<=rom_duration.
    - Tick counter cleared; go to PLAY.
  - During LOAD, divisor and tone_en keep their previous values, so the divider never sees a spurious 0.
- PLAY:
  - Tick counter runs 0..TICK_CYCLES-1 and wraps; a tick fires when it equals TICK_CYCLES-1.
  - On each tick, dur_cnt decrements.
  - On the tick where dur_cnt==1, leave PLAY.
  - PLAY therefore lasts exactly D*TICK_CYCLES cycles for duration D.
  - Leaving PLAY when rom_addr==2^AW-1: treated as end of table (same loop/done rule as a marker at a nonzero address), with no address overflow.
  - Leaving PLAY otherwise: rom_addr increments, go to LOAD.
- Timing:
  - start sampled at cycle N → LOAD at N+1 → divisor valid from N+2.
  - Note-to-note period is D*TICK_CYCLES+1 cycles.
- stop (any non-IDLE state):
  - Next cycle: IDLE, divisor=0, tone_en=0, rom_addr=0, no done.
  - stop has priority over start and over end-of-table.
- start while busy: ignored, no restart.
- done and busy are never both 1.

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- Defined:
  - A GAP state is inserted after each PLAY, before the next LOAD or end handling.
  - GAP lasts exactly 1 tick (TICK_CYCLES cycles); tone_en=0 and divisor holds its value.
  - Gives audible separation of repeated notes.
  - Note-to-note period becomes (D+1)*TICK_CYCLES+1 cycles.
  - stop during GAP behaves as in any other non-IDLE state.
- Undefined:
  - No GAP state; PLAY goes directly to LOAD. Timing as in Behaviour.

Test Plan (TICK_CYCLES=4, AW=2 unless noted):
- Table {(10,2),(6,1),(x,0)}, start pulse at cycle 0 → divisor=10, tone_en=1 cycles 2–9; divisor 10 held through LOAD at 10; divisor=6 cycles 11–14; LOAD at 15; done=1 at cycle 16 with divisor=0, busy=0.
- Same table, loop=1 → after the 6-note, rom_addr returns to 0 and divisor=10 reappears; done never asserts; stop then returns to IDLE within 1 cycle.
- Entry (0,3) → busy=1, tone_en=0 for 12 cycles, divisor=0; next entry plays normally.
- stop at cycle 5 of a note → cycle 6: IDLE, divisor=0, tone_en=0, no done. start and stop in the same cycle from IDLE → stays IDLE.
- reset_n low asynchronously mid-PLAY, between edges → all outputs 0 immediately; start after release plays from entry 0.
- All 4 entries with nonzero duration, loop=0 → done after entry 3 with no address wrap. Table with entry 0 = (x,0), loop=1 → done 2 cycles after start, no hang. With TONE_SEQ_GAP_EN → 4-cycle tone_en=0 gap between notes.
